// File: rtl/inst_mem_loadable_if.sv
// Fetch and program-load bus for inst_mem_loadable.
//   master: fetch stage / load bridge side (drives requests and load bytes)
//   slave : instruction memory side (drives fetched data and load status)
// Fetch: fetch_en, stall, addr_in -> data_out, data_valid, addr_fault
// Load : load_start, load_byte, load_byte_valid, load_last ->
//        load_ready, load_busy, load_done, load_overflow
interface inst_mem_loadable_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fetch_en;
    logic                  stall;
    logic [31:0]           addr_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  addr_fault;
    logic                  load_start;
    logic [7:0]            load_byte;
    logic                  load_byte_valid;
    logic                  load_last;
    logic                  load_ready;
    logic                  load_busy;
    logic                  load_done;
    logic                  load_overflow;

    modport master (
        output fetch_en, stall, addr_in,
        output load_start, load_byte, load_byte_valid, load_last,
        input  data_out, data_valid, addr_fault,
        input  load_ready, load_busy, load_done, load_overflow
    );

    modport slave (
        input  fetch_en, stall, addr_in,
        input  load_start, load_byte, load_byte_valid, load_last,
        output data_out, data_valid, addr_fault,
        output load_ready, load_busy, load_done, load_overflow
    );
endinterface

// File: rtl/inst_mem_loadable.sv
// Synchronous-read instruction memory with a byte-serial program-load port.
// Ports:
//   clock  - system clock, all logic on posedge
//   reset  - synchronous, active-high; memory contents are preserved
//   bus    - inst_mem_loadable_if.slave: fetch request/response and
//            load byte stream with load status flags
// Fetch has one-cycle latency; stall holds the fetch outputs. Fetches are
// ignored while a load is in progress. The load FSM packs NB bytes per
// word and writes each assembled word in a dedicated WRITE cycle.
module inst_mem_loadable #(
  parameter int    ADDR_WIDTH   = 8,
  parameter int    DATA_WIDTH   = 32,
  parameter string INIT_PROGRAM = "",
  parameter bit    BYTE_SWAP    = 1'b0
) (
  input logic                clock,
  input logic                reset,
  inst_mem_loadable_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(NB);
  localparam logic [OFF-1:0] LANE_MAX = OFF'(NB - 1);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} load_state_t;

  load_state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // wptr has one extra bit so it can saturate at DEPTH (overflow marker)
  logic [ADDR_WIDTH:0]   wptr;
  logic [OFF-1:0]        bcnt;
  logic [OFF-1:0]        lane;
  logic [DATA_WIDTH-1:0] asm_word;
  logic                  last_seen;
  logic                  overflow;
  logic                  byte_accept;
  logic                  word_complete;

  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic                  fetch_bad;
  logic                  busy;

  assign byte_accept   = (state == RECV) && bus.load_byte_valid;
  assign word_complete = byte_accept && ((bcnt == LANE_MAX) || bus.load_last);
  assign lane          = BYTE_SWAP ? (LANE_MAX - bcnt) : bcnt;

  assign fetch_idx = bus.addr_in[ADDR_WIDTH+OFF-1:OFF];
  assign fetch_bad = (|bus.addr_in[OFF-1:0]) || (|bus.addr_in[31:ADDR_WIDTH+OFF]);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and status outputs
  always_comb begin
    state_next     = state;
    busy           = 1'b1;
    bus.load_ready = 1'b0;
    bus.load_done  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.load_start) begin
          state_next = RECV;
        end
      end
      RECV: begin
        bus.load_ready = 1'b1;
        if (word_complete) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = last_seen ? DONE : RECV;
      end
      DONE: begin
        bus.load_done = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.load_busy     = busy;
  assign bus.load_overflow = overflow;

  // Load datapath: byte assembly, word pointer, overflow flag
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr      <= '0;
      bcnt      <= '0;
      asm_word  <= '0;
      last_seen <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_start) begin
            wptr      <= '0;
            bcnt      <= '0;
            asm_word  <= '0;
            last_seen <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        RECV: begin
          if (byte_accept) begin
            asm_word[{lane, 3'b000} +: 8] <= bus.load_byte;
            bcnt <= bcnt + 1'b1;
            if (bus.load_last) begin
              last_seen <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (wptr[ADDR_WIDTH]) begin
            overflow <= 1'b1;
          end else begin
            wptr <= wptr + 1'b1;
          end
          asm_word <= '0;
          bcnt     <= '0;
        end
        default: ;
      endcase
    end
  end

  // Memory write port; a write cycle coinciding with reset is abandoned
  always_ff @(posedge clock) begin
    if (!reset && (state == WRITE) && !wptr[ADDR_WIDTH]) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= asm_word;
    end
  end

  // Fetch port: busy beats stall, stall beats fetch_en
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.addr_fault <= 1'b0;
    end else if (busy) begin
      bus.data_valid <= 1'b0;
      bus.addr_fault <= 1'b0;
    end else if (bus.stall) begin
      bus.data_valid <= bus.data_valid;
    end else if (bus.fetch_en) begin
      bus.data_valid <= 1'b1;
      if (fetch_bad) begin
        bus.data_out   <= '0;
        bus.addr_fault <= 1'b1;
      end else begin
        bus.data_out   <= mem[fetch_idx];
        bus.addr_fault <= 1'b0;
      end
    end else begin
      bus.data_valid <= 1'b0;
      bus.addr_fault <= 1'b0;
    end
  end
endmodule

// File: tb/tb_inst_mem_loadable.sv
// Bench for inst_mem_loadable. Two instances share one stimulus stream:
//   dut_a: ADDR_WIDTH=8, BYTE_SWAP=0
//   dut_b: ADDR_WIDTH=2, BYTE_SWAP=1
// Expected fetch results are queued at issue time and popped by a monitor
// whenever data_valid is seen.
module tb_inst_mem_loadable;
    typedef struct {
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        fetch_en, stall, load_start, load_byte_valid, load_last;
    logic [31:0] addr_in;
    logic [7:0]  load_byte;

    inst_mem_loadable_if #(.DATA_WIDTH(32)) bus_a ();
    inst_mem_loadable_if #(.DATA_WIDTH(32)) bus_b ();

    assign bus_a.fetch_en = fetch_en;        assign bus_b.fetch_en = fetch_en;
    assign bus_a.stall = stall;              assign bus_b.stall = stall;
    assign bus_a.addr_in = addr_in;          assign bus_b.addr_in = addr_in;
    assign bus_a.load_start = load_start;    assign bus_b.load_start = load_start;
    assign bus_a.load_byte = load_byte;      assign bus_b.load_byte = load_byte;
    assign bus_a.load_byte_valid = load_byte_valid;
    assign bus_b.load_byte_valid = load_byte_valid;
    assign bus_a.load_last = load_last;      assign bus_b.load_last = load_last;

    inst_mem_loadable #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .INIT_PROGRAM(""), .BYTE_SWAP(1'b0))
        dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    inst_mem_loadable #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .INIT_PROGRAM(""), .BYTE_SWAP(1'b1))
        dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad = 0;
    int   done_a = 0;
    int   done_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_rst(input string p, input logic [31:0] d, input logic v, input logic f,
                             input logic r, input logic dn, input logic ov, input logic bz);
        check({p, "_rst_data"}, d, 32'h0);
        check({p, "_rst_valid"}, {31'b0, v}, 32'h0);
        check({p, "_rst_fault"}, {31'b0, f}, 32'h0);
        check({p, "_rst_ready"}, {31'b0, r}, 32'h0);
        check({p, "_rst_done"}, {31'b0, dn}, 32'h0);
        check({p, "_rst_ovf"}, {31'b0, ov}, 32'h0);
        check({p, "_rst_busy"}, {31'b0, bz}, 32'h0);
    endtask

    // Monitor: every cycle with data_valid consumes one expected entry
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (bus_a.data_valid === 1'b1) begin
                if (q_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_unexpected_valid: got data %h with nothing expected", bus_a.data_out);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    check("a_data", bus_a.data_out, e.data);
                    check("a_fault", {31'b0, bus_a.addr_fault}, {31'b0, e.fault});
                end
            end
            if (bus_b.data_valid === 1'b1) begin
                if (q_b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_unexpected_valid: got data %h with nothing expected", bus_b.data_out);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    check("b_data", bus_b.data_out, e.data);
                    check("b_fault", {31'b0, bus_b.addr_fault}, {31'b0, e.fault});
                end
            end
        end
        if (bus_a.load_done === 1'b1) done_a++;
        if (bus_b.load_done === 1'b1) done_b++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input logic [31:0] da, input logic fa, input logic [31:0] db, input logic fb);
        exp_t ea, eb;
        ea.data = da; ea.fault = fa;
        eb.data = db; eb.fault = fb;
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] da, input logic fa,
                         input logic [31:0] db, input logic fb);
        fetch_en = 1'b1;
        addr_in  = addr;
        expect_out(da, fa, db, fb);
        step();
        fetch_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit acc;
        acc = 1'b0;
        load_byte_valid = 1'b1;
        load_byte       = b;
        load_last       = last;
        for (int i = 0; i < 20; i++) begin
            if (bus_a.load_ready === 1'b1) begin
                acc = 1'b1;
                step();
                break;
            end
            step();
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL load_ready_timeout: got ready=0 for byte %h expected ready=1", b);
        end
        load_byte_valid = 1'b0;
        load_last       = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus_a.load_busy === 1'b0 && bus_b.load_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL load_busy_timeout: got busy=1 expected busy=0");
        end
        step();
    endtask

    initial begin
        logic [7:0] img1 [8];
        img1 = '{8'h05, 8'h00, 8'h08, 8'h20, 8'h04, 8'h00, 8'h09, 8'h8C};

        fetch_en = 0; stall = 0; addr_in = '0; load_start = 0;
        load_byte = '0; load_byte_valid = 0; load_last = 0;
        reset = 1'b1;
        step(); step();
        check_rst("a", bus_a.data_out, bus_a.data_valid, bus_a.addr_fault, bus_a.load_ready,
                  bus_a.load_done, bus_a.load_overflow, bus_a.load_busy);
        check_rst("b", bus_b.data_out, bus_b.data_valid, bus_b.addr_fault, bus_b.load_ready,
                  bus_b.load_done, bus_b.load_overflow, bus_b.load_busy);
        reset = 1'b0;
        step();

        // Program image: word0=0x20080005, word1=0x8C090004 (swapped in dut_b)
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(img1[i], i == 7);
        wait_idle();
        check("a_done_cnt1", done_a, 1);
        check("b_done_cnt1", done_b, 1);

        fetch(32'h0, 32'h20080005, 0, 32'h05000820, 0);
        fetch(32'h4, 32'h8C090004, 0, 32'h0400098C, 0);
        fetch(32'h2, 32'h0, 1, 32'h0, 1);
        fetch(32'h400, 32'h0, 1, 32'h0, 1);
        step();

        // Stall holds result while the address keeps moving
        fetch(32'h4, 32'h8C090004, 0, 32'h0400098C, 0);
        for (int i = 0; i < 3; i++) begin
            stall    = 1'b1;
            fetch_en = 1'b1;
            addr_in  = 32'h8 * i;
            expect_out(32'h8C090004, 0, 32'h0400098C, 0);
            step();
        end
        stall = 1'b0; fetch_en = 1'b0;
        step();

        // load_start together with a fetch: the fetch still completes
        load_start = 1'b1; fetch_en = 1'b1; addr_in = 32'h4;
        expect_out(32'h8C090004, 0, 32'h0400098C, 0);
        step();
        load_start = 1'b0;
        addr_in = 32'h0;   // fetch_en left high: must be ignored while busy
        step();
        fetch_en = 1'b0;
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        load_start = 1'b1; // ignored while busy
        send_byte(8'h34, 0);
        load_start = 1'b0;
        send_byte(8'h12, 0);
        send_byte(8'hAA, 1);
        wait_idle();
        check("a_done_cnt2", done_a, 2);
        check("b_done_cnt2", done_b, 2);
        fetch(32'h0, 32'h12345678, 0, 32'h78563412, 0);
        fetch(32'h4, 32'h000000AA, 0, 32'hAA000000, 0);
        step();

        // Five-word image: dut_b (4 words deep) must overflow
        pulse_start();
        for (int i = 0; i < 20; i++) send_byte(8'h10 + 8'(i), i == 19);
        wait_idle();
        check("a_done_cnt3", done_a, 3);
        check("b_done_cnt3", done_b, 3);
        check("a_ovf", {31'b0, bus_a.load_overflow}, 32'h0);
        check("b_ovf", {31'b0, bus_b.load_overflow}, 32'h1);
        fetch(32'h0, 32'h13121110, 0, 32'h10111213, 0);
        fetch(32'hC, 32'h1F1E1D1C, 0, 32'h1C1D1E1F, 0);
        fetch(32'h10, 32'h23222120, 0, 32'h0, 1);
        step();
        check("b_ovf_sticky", {31'b0, bus_b.load_overflow}, 32'h1);

        // New load clears overflow; reset after 6 of 8 bytes aborts it
        pulse_start();
        check("b_ovf_cleared", {31'b0, bus_b.load_overflow}, 32'h0);
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 0);
        reset = 1'b1;
        step();
        check_rst("a", bus_a.data_out, bus_a.data_valid, bus_a.addr_fault, bus_a.load_ready,
                  bus_a.load_done, bus_a.load_overflow, bus_a.load_busy);
        check_rst("b", bus_b.data_out, bus_b.data_valid, bus_b.addr_fault, bus_b.load_ready,
                  bus_b.load_done, bus_b.load_overflow, bus_b.load_busy);
        reset = 1'b0;
        step();
        check("a_done_cnt4", done_a, 3);
        check("b_done_cnt4", done_b, 3);
        fetch(32'h0, 32'hA3A2A1A0, 0, 32'hA0A1A2A3, 0);
        fetch(32'h4, 32'h17161514, 0, 32'h14151617, 0);
        step(); step();

        check("a_queue_empty", q_a.size(), 0);
        check("b_queue_empty", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
